// File: rtl/sample_func.sv
// Sum-product factor node over a constant 3x2x2 factor f(g,i,d) in 1/256 units.
// Inputs are registered, each output message is computed from the captured inputs and registered.

module sample_func_acc #(
  parameter int NUM_TERMS = 4
) (
  input  logic [NUM_TERMS-1:0][7:0] fac,
  input  logic [NUM_TERMS-1:0][7:0] a,
  input  logic [NUM_TERMS-1:0][7:0] b,
  output logic [7:0]                msg
);
  // Exact 24-bit products; 27 bits holds six full-scale terms without overflow.
  logic [26:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TERMS; k++)
      acc = acc + 27'(fac[k]) * 27'(a[k]) * 27'(b[k]);
  end

  assign msg = (|acc[26:16]) ? 8'hFF : acc[15:8];
endmodule

module sample_func (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] grade0In,
  input  logic [7:0] grade1In,
  input  logic [7:0] grade2In,
  input  logic [7:0] intel0In,
  input  logic [7:0] intel1In,
  input  logic [7:0] diff0In,
  input  logic [7:0] diff1In,
  output logic [7:0] grade0,
  output logic [7:0] grade1,
  output logic [7:0] grade2,
  output logic [7:0] intel0,
  output logic [7:0] intel1,
  output logic [7:0] diff0,
  output logic [7:0] diff1
);
  localparam int NG = 3;
  localparam int NI = 2;
  localparam int ND = 2;

  function automatic logic [7:0] ftab(input logic [1:0] g, input logic i, input logic d);
    case ({g, i, d})
      4'b0000: ftab = 8'd77;
      4'b0001: ftab = 8'd13;
      4'b0010: ftab = 8'd230;
      4'b0011: ftab = 8'd128;
      4'b0100: ftab = 8'd102;
      4'b0101: ftab = 8'd64;
      4'b0110: ftab = 8'd20;
      4'b0111: ftab = 8'd77;
      4'b1000: ftab = 8'd77;
      4'b1001: ftab = 8'd179;
      4'b1010: ftab = 8'd6;
      4'b1011: ftab = 8'd51;
      default: ftab = 8'd0;
    endcase
  endfunction

  logic [NG-1:0][7:0] grade_q, grade_d, grade_r;
  logic [NI-1:0][7:0] intel_q, intel_d, intel_r;
  logic [ND-1:0][7:0] diff_q,  diff_d,  diff_r;

  // Grade messages: marginalise over (i,d), term index i*2+d.
  for (genvar g = 0; g < NG; g++) begin : g_grade
    logic [NI*ND-1:0][7:0] fac, a, b;
    for (genvar i = 0; i < NI; i++) begin : g_i
      for (genvar d = 0; d < ND; d++) begin : g_d
        assign fac[i*ND+d] = ftab(2'(g), 1'(i), 1'(d));
        assign a[i*ND+d]   = intel_q[i];
        assign b[i*ND+d]   = diff_q[d];
      end
    end
    sample_func_acc #(.NUM_TERMS(NI*ND)) u_acc (.fac(fac), .a(a), .b(b), .msg(grade_d[g]));
  end

  // Intelligence messages: marginalise over (g,d), term index g*2+d.
  for (genvar i = 0; i < NI; i++) begin : g_intel
    logic [NG*ND-1:0][7:0] fac, a, b;
    for (genvar g = 0; g < NG; g++) begin : g_g
      for (genvar d = 0; d < ND; d++) begin : g_d
        assign fac[g*ND+d] = ftab(2'(g), 1'(i), 1'(d));
        assign a[g*ND+d]   = grade_q[g];
        assign b[g*ND+d]   = diff_q[d];
      end
    end
    sample_func_acc #(.NUM_TERMS(NG*ND)) u_acc (.fac(fac), .a(a), .b(b), .msg(intel_d[i]));
  end

  // Difficulty messages: marginalise over (g,i), term index g*2+i.
  for (genvar d = 0; d < ND; d++) begin : g_diff
    logic [NG*NI-1:0][7:0] fac, a, b;
    for (genvar g = 0; g < NG; g++) begin : g_g
      for (genvar i = 0; i < NI; i++) begin : g_i
        assign fac[g*NI+i] = ftab(2'(g), 1'(i), 1'(d));
        assign a[g*NI+i]   = grade_q[g];
        assign b[g*NI+i]   = intel_q[i];
      end
    end
    sample_func_acc #(.NUM_TERMS(NG*NI)) u_acc (.fac(fac), .a(a), .b(b), .msg(diff_d[d]));
  end

  // Clearing the input stage too ensures nothing captured before reset reaches the outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      grade_q <= '0;
      intel_q <= '0;
      diff_q  <= '0;
      grade_r <= '0;
      intel_r <= '0;
      diff_r  <= '0;
    end else begin
      grade_q <= {grade2In, grade1In, grade0In};
      intel_q <= {intel1In, intel0In};
      diff_q  <= {diff1In, diff0In};
      grade_r <= grade_d;
      intel_r <= intel_d;
      diff_r  <= diff_d;
    end
  end

  assign grade0 = grade_r[0];
  assign grade1 = grade_r[1];
  assign grade2 = grade_r[2];
  assign intel0 = intel_r[0];
  assign intel1 = intel_r[1];
  assign diff0  = diff_r[0];
  assign diff1  = diff_r[1];
endmodule

// File: tb/tb_sample_func.sv
// Directed bench for sample_func: per-cycle check against an arithmetic model plus literal anchors.

module tb_sample_func;
  logic       Clk_tb;
  logic       reset;
  logic [7:0] g_in [3];
  logic [7:0] i_in [2];
  logic [7:0] d_in [2];
  logic [7:0] grade0, grade1, grade2, intel0, intel1, diff0, diff1;

  int n_vec  = 0;
  int n_miss = 0;

  sample_func dut (
    .Clk(Clk_tb), .Reset(reset),
    .grade0In(g_in[0]), .grade1In(g_in[1]), .grade2In(g_in[2]),
    .intel0In(i_in[0]), .intel1In(i_in[1]),
    .diff0In(d_in[0]),  .diff1In(d_in[1]),
    .grade0(grade0), .grade1(grade1), .grade2(grade2),
    .intel0(intel0), .intel1(intel1),
    .diff0(diff0),   .diff1(diff1)
  );

  initial Clk_tb = 1'b0;
  always #5 Clk_tb = ~Clk_tb;

  // Factor table indexed [g][i][d].
  int fac [3][2][2] = '{ '{ '{77, 13},  '{230, 128} },
                         '{ '{102, 64}, '{20, 77} },
                         '{ '{77, 179}, '{6, 51} } };

  // Vectors are packed {g0,g1,g2,i0,i1,d0,d1}, one byte each, g0 in the top byte.
  function automatic logic [7:0] sat(input int s);
    sat = ((s >> 8) > 255) ? 8'd255 : 8'((s >> 8));
  endfunction

  function automatic logic [55:0] model(input logic [55:0] v);
    int gr [3];
    int it [2];
    int df [2];
    int acc;
    logic [7:0] o [7];
    for (int k = 0; k < 3; k++) gr[k] = int'(v[55-8*k -: 8]);
    for (int k = 0; k < 2; k++) it[k] = int'(v[31-8*k -: 8]);
    for (int k = 0; k < 2; k++) df[k] = int'(v[15-8*k -: 8]);
    for (int g = 0; g < 3; g++) begin
      acc = 0;
      for (int i = 0; i < 2; i++) for (int d = 0; d < 2; d++) acc += fac[g][i][d] * it[i] * df[d];
      o[g] = sat(acc);
    end
    for (int i = 0; i < 2; i++) begin
      acc = 0;
      for (int g = 0; g < 3; g++) for (int d = 0; d < 2; d++) acc += fac[g][i][d] * gr[g] * df[d];
      o[3+i] = sat(acc);
    end
    for (int d = 0; d < 2; d++) begin
      acc = 0;
      for (int g = 0; g < 3; g++) for (int i = 0; i < 2; i++) acc += fac[g][i][d] * gr[g] * it[i];
      o[5+d] = sat(acc);
    end
    model = {o[0], o[1], o[2], o[3], o[4], o[5], o[6]};
  endfunction

  logic [55:0] in_vec, out_vec;
  assign in_vec  = {g_in[0], g_in[1], g_in[2], i_in[0], i_in[1], d_in[0], d_in[1]};
  assign out_vec = {grade0, grade1, grade2, intel0, intel1, diff0, diff1};

  // Outputs after an edge are the model of the inputs seen one edge earlier,
  // or zero if reset was low at either of those two edges.
  logic [55:0] exp_vec   = '0;
  logic [55:0] prev_in   = '0;
  logic        prev_rst  = 1'b0;
  logic        exp_valid = 1'b0;

  always @(posedge Clk_tb) begin
    if (!reset || !prev_rst) exp_vec <= '0;
    else                     exp_vec <= model(prev_in);
    prev_in   <= in_vec;
    prev_rst  <= reset;
    exp_valid <= 1'b1;
  end

  always @(negedge Clk_tb) begin
    if (exp_valid) begin
      n_vec++;
      if (out_vec !== exp_vec) begin
        n_miss++;
        $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, out_vec, exp_vec);
      end
    end
  end

  task automatic set_in(input logic [55:0] v);
    for (int k = 0; k < 3; k++) g_in[k] = v[55-8*k -: 8];
    for (int k = 0; k < 2; k++) i_in[k] = v[31-8*k -: 8];
    for (int k = 0; k < 2; k++) d_in[k] = v[15-8*k -: 8];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk_tb);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [55:0] want);
    n_vec++;
    if (out_vec !== want) begin
      n_miss++;
      $display("FAIL %s got=%h expected=%h", name, out_vec, want);
    end
  endtask

  logic [55:0] rv;

  initial begin
    reset = 1'b0;
    set_in(56'h0123456789ABCD);
    // Reset hold with changing inputs: outputs pinned at zero.
    for (int k = 0; k < 3; k++) begin
      tick(1);
      rv = {$urandom, $urandom};
      set_in(rv);
      check_lit("reset_hold", 56'h0);
    end

    // All ones, reset released together with the new inputs.
    set_in(56'h01010101010101);
    reset = 1'b1;
    tick(1);
    check_lit("release_first_edge", 56'h0);
    tick(1);
    check_lit("all_ones", 56'h01010102020202);

    set_in(56'h01000001010101);
    tick(1);
    check_lit("grade_change_one_edge", 56'h01010102020202);
    tick(1);
    check_lit("grade_100", 56'h01010100010100);

    set_in(56'h01010102040101);
    tick(2);
    check_lit("intel_24", 56'h06020202020606);
    tick(2);
    check_lit("intel_24_hold", 56'h06020202020606);

    set_in({7{8'hFF}});
    tick(2);
    check_lit("saturate", {7{8'hFF}});

    set_in('0);
    tick(2);
    check_lit("all_zero", 56'h0);

    // Directed spot vectors, held two edges each, checked by the model process.
    set_in(56'h10203040506070); tick(2);
    set_in(56'hFF000000FF00FF); tick(2);
    set_in(56'h0000FFFF00FF00); tick(2);
    set_in(56'h80808080808080); tick(2);
    // Input changing every cycle exercises the two-edge latency.
    for (int k = 0; k < 8; k++) begin
      rv = {$urandom, $urandom};
      set_in(rv);
      tick(1);
    end

    // Reset one edge after an input change: pending result must never appear.
    set_in({7{8'hFF}});
    tick(2);
    set_in(56'h01010101010101);
    tick(1);
    reset = 1'b0;
    tick(1);
    check_lit("reset_discard_0", 56'h0);
    tick(1);
    check_lit("reset_discard_1", 56'h0);
    reset = 1'b1;
    tick(1);
    check_lit("reset_discard_2", 56'h0);
    tick(1);
    check_lit("after_reset_result", 56'h01010102020202);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sample_func.md
SAMPLE_FUNC -- requirements
Module: sample_func

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state updates on the rising edge of Clk.
REQ-002 Ports SHALL be, in this order:
- Clk  input  1  clock
- Reset  input  1  synchronous active-low reset
- grade0In, grade1In, grade2In  input  8 each  incoming messages for Grade states g0..g2
- intel0In, intel1In  input  8 each  incoming messages for Intelligence states i0..i1
- diff0In, diff1In  input  8 each  incoming messages for Difficulty states d0..d1
- grade0, grade1, grade2  output  8 each  outgoing message to Grade
- intel0, intel1  output  8 each  outgoing message to Intelligence
- diff0, diff1  output  8 each  outgoing message to Difficulty
REQ-003 All message values SHALL be unsigned 8-bit integers; there are no parameters.

Function
REQ-004 The block SHALL implement a sum-product factor node for a constant factor f(g,i,d), stored as 8-bit unsigned entries in units of 1/256.
REQ-005 Factor table, listed as f(g0,g1,g2) for each (i,d):
- (i0,d0) = 77,102,77
- (i0,d1) = 13,64,179
- (i1,d0) = 230,20,6
- (i1,d1) = 128,77,51
REQ-006 grade_g SHALL equal the sum over i,d of f(g,i,d)*intel_i*diff_d; the grade inputs SHALL NOT be used for this output.
REQ-007 intel_i SHALL equal the sum over g,d of f(g,i,d)*grade_g*diff_d; the intel inputs SHALL NOT be used for this output.
REQ-008 diff_d SHALL equal the sum over g,i of f(g,i,d)*grade_g*intel_i; the diff inputs SHALL NOT be used for this output.
REQ-009 Arithmetic rules:
- each product is exact (24-bit);
- the accumulation is exact (at least 27 bits);
- the result is the sum shifted right by 8 (truncation);
- any result above 255 saturates to 255.
REQ-010 Inputs SHALL be captured into an input register on every rising edge. Outputs SHALL be registered from the captured values.
REQ-011 Latency: a change on any input SHALL appear on the outputs exactly 2 rising edges later.
REQ-012 Outputs SHALL then hold steady while the inputs are stable. There is no handshake; the block computes continuously.
REQ-013 All seven outputs SHALL update in the same cycle; there are no partial updates.

Reset
REQ-014 While Reset=0 at a rising edge, the input registers and all outputs SHALL be cleared to 0.
REQ-015 Asserting reset mid-operation SHALL discard in-flight values; no output from pre-reset inputs appears after reset.
REQ-016 After Reset returns to 1, the first valid outputs SHALL appear 2 rising edges later, computed from the inputs present at the first of those edges.

Verification
REQ-017 Reset hold: Reset=0 for 3 cycles with arbitrary inputs -> all outputs = 0 throughout.
REQ-018 All inputs = 1, Reset released -> after 2 edges:
- grade = 1,1,1
- intel = 2,2
- diff = 2,2
REQ-019 Grade inputs changed to 1,0,0 (others 1) -> 2 edges later:
- intel = 0,1
- diff = 1,0
- grade = 1,1,1 (unchanged)
REQ-020 Intel inputs changed to 2,4 (others 1) -> 2 edges later:
- grade = 6,2,2
- diff = 6,6
- intel = 2,2
REQ-021 Saturation: all inputs = 255 -> every output = 255.
REQ-022 Reset asserted one cycle after an input change -> outputs stay 0 and never show the pending result.
